// File: rtl/am_lane_rx.sv
// Per-lane alignment marker receiver: marker search and lock, marker removal, BIP3 check.
// Optional BIP logic is built only when AM_LANE_RX_BIP_CHECK_EN is defined.
module am_lane_rx #(
  parameter int          HEAD_W      = 2,
  parameter int          DATA_W      = 64,
  parameter int          BLOCK_W     = HEAD_W + DATA_W,
  parameter logic [63:0] LANE_ENC    = 64'h00b8_896f_0047_7690,
  parameter int          AM_GAP      = 16383,
  parameter int          AM_LOSS_CNT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_i,
  input  logic [BLOCK_W-1:0] data_i,
  output logic               valid_o,
  output logic [BLOCK_W-1:0] data_o,
  output logic               am_v_o,
  output logic               lock_o,
  output logic               bip_err_o
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = $clog2(AM_GAP + 1);
  localparam int MISS_W = (AM_LOSS_CNT > 1) ? $clog2(AM_LOSS_CNT + 1) : 1;

  typedef enum logic [1:0] {
    SEEK,
    CHECK,
    LOCKED
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [MISS_W-1:0]   r_miss;
  logic [MISS_W-1:0]   w_miss_nxt;
  logic [BLOCK_W-1:0]  r_data;
  logic                r_valid;
  logic                r_am_v;

  logic [7:0]          w_byte [NBYTES];
  logic                w_match;
  logic                w_slot;
  logic                w_remove;
  logic                w_arm;
  logic                w_disarm;
  logic                w_chk;

  always_comb begin
    for (int unsigned i = 0; i < NBYTES; i++) begin
      w_byte[i] = data_i[HEAD_W + 8*i +: 8];
    end
  end

  // Bytes 3 and 7 carry BIP3 and its complement, so only their relationship is matched.
  assign w_match = (data_i[1:0] == 2'b10)
                && (w_byte[0] == LANE_ENC[7:0])
                && (w_byte[1] == LANE_ENC[15:8])
                && (w_byte[2] == LANE_ENC[23:16])
                && (w_byte[4] == LANE_ENC[39:32])
                && (w_byte[5] == LANE_ENC[47:40])
                && (w_byte[6] == LANE_ENC[55:48])
                && (w_byte[7] == ~w_byte[3]);

  assign w_slot = (r_cnt == CNT_W'(AM_GAP));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_miss_nxt  = r_miss;
    w_remove    = 1'b0;
    w_arm       = 1'b0;
    w_disarm    = 1'b0;
    w_chk       = 1'b0;
    if (valid_i) begin
      case (r_state)
        SEEK: begin
          if (w_match) begin
            w_state_nxt = CHECK;
            w_cnt_nxt   = '0;
            w_remove    = 1'b1;
            w_arm       = 1'b1;
          end
        end
        CHECK: begin
          if (!w_slot) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end else if (w_match) begin
            w_state_nxt = LOCKED;
            w_cnt_nxt   = '0;
            w_miss_nxt  = '0;
            w_remove    = 1'b1;
            w_arm       = 1'b1;
          end else begin
            w_state_nxt = SEEK;
            w_cnt_nxt   = '0;
            w_disarm    = 1'b1;
          end
        end
        LOCKED: begin
          if (!w_slot) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end else begin
            // Every slot block is consumed while locked, marker or not.
            w_remove  = 1'b1;
            w_cnt_nxt = '0;
            if (w_match) begin
              w_miss_nxt = '0;
              w_arm      = 1'b1;
              w_chk      = 1'b1;
            end else if (r_miss == MISS_W'(AM_LOSS_CNT - 1)) begin
              w_state_nxt = SEEK;
              w_miss_nxt  = '0;
              w_disarm    = 1'b1;
            end else begin
              w_miss_nxt = r_miss + MISS_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = SEEK;
          w_cnt_nxt   = '0;
          w_miss_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SEEK;
      r_cnt   <= '0;
      r_miss  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_am_v  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_miss  <= w_miss_nxt;
      r_data  <= data_i;
      r_valid <= valid_i & ~w_remove;
      r_am_v  <= valid_i & w_remove;
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign am_v_o  = r_am_v;
  assign lock_o  = (r_state == LOCKED);

`ifdef AM_LANE_RX_BIP_CHECK_EN
  logic [7:0] r_acc;
  logic       r_armed;
  logic       r_bip_err;
  logic [7:0] w_par;

  // Header bits fold into BIP positions 3 and 4; payload bit k lands on BIP bit k mod 8.
  always_comb begin
    w_par = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      w_par = w_par ^ w_byte[i];
    end
    w_par[3] = w_par[3] ^ data_i[0];
    w_par[4] = w_par[4] ^ data_i[1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc     <= '0;
      r_armed   <= 1'b0;
      r_bip_err <= 1'b0;
    end else begin
      r_bip_err <= w_chk & r_armed & (w_byte[3] != r_acc);
      if (valid_i) begin
        r_acc <= w_remove ? w_par : (r_acc ^ w_par);
        if (w_disarm) begin
          r_armed <= 1'b0;
        end else if (w_arm) begin
          r_armed <= 1'b1;
        end
      end
    end
  end

  assign bip_err_o = r_bip_err;
`else
  logic w_unused_bip;
  assign w_unused_bip = ^{w_arm, w_disarm, w_chk};
  assign bip_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_am_lane_rx.sv
// Self-checking bench for am_lane_rx: directed marker scenarios plus randomized stream vs a reference model.
module tb_am_lane_rx;

  localparam int          HEAD_W  = 2;
  localparam int          DATA_W  = 64;
  localparam int          BLOCK_W = HEAD_W + DATA_W;
  localparam int          GAP     = 4;
  localparam int          LOSS    = 4;
  localparam logic [63:0] ENC     = 64'h00b8_896f_0047_7690;

`ifdef AM_LANE_RX_BIP_CHECK_EN
  localparam bit BIP_EN = 1'b1;
`else
  localparam bit BIP_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               valid_i;
  logic [BLOCK_W-1:0] data_i;
  logic               valid_o;
  logic [BLOCK_W-1:0] data_o;
  logic               am_v_o;
  logic               lock_o;
  logic               bip_err_o;

  am_lane_rx #(
    .HEAD_W      (HEAD_W),
    .DATA_W      (DATA_W),
    .BLOCK_W     (BLOCK_W),
    .LANE_ENC    (ENC),
    .AM_GAP      (GAP),
    .AM_LOSS_CNT (LOSS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_i   (valid_i),
    .data_i    (data_i),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .am_v_o    (am_v_o),
    .lock_o    (lock_o),
    .bip_err_o (bip_err_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: lock status, pending candidate, blocks since last slot, misses, running parity.
  bit         m_lock, m_cand, m_armed;
  int         m_since, m_miss;
  logic [7:0] m_acc;

  function automatic logic [7:0] ref_par(input logic [BLOCK_W-1:0] b);
    logic [7:0] p = '0;
    for (int j = 0; j < BLOCK_W; j++) begin
      int idx;
      if (j >= 2) idx = (j - 2) % 8;
      else        idx = (j == 0) ? 3 : 4;
      p[idx] = p[idx] ^ b[j];
    end
    return p;
  endfunction

  function automatic bit ref_is_marker(input logic [BLOCK_W-1:0] b);
    logic [63:0] enc = ENC;
    bit ok = (b[1:0] == 2'b10);
    for (int k = 0; k < 7; k++) begin
      if (k != 3 && b[2+8*k +: 8] != enc[8*k +: 8]) ok = 1'b0;
    end
    if (b[2+56 +: 8] != ~b[2+24 +: 8]) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [BLOCK_W-1:0] mk_marker(input logic [7:0] bip);
    logic [63:0]        enc = ENC;
    logic [BLOCK_W-1:0] b = '0;
    b[1:0] = 2'b10;
    for (int k = 0; k < 8; k++) b[2+8*k +: 8] = enc[8*k +: 8];
    b[2+24 +: 8] = bip;
    b[2+56 +: 8] = ~bip;
    return b;
  endfunction

  function automatic logic [BLOCK_W-1:0] mk_data();
    logic [95:0]        r = {$urandom(), $urandom(), $urandom()};
    logic [BLOCK_W-1:0] b = r[BLOCK_W-1:0];
    b[1:0] = 2'b01;
    return b;
  endfunction

  task automatic model_clear();
    m_lock = 0; m_cand = 0; m_armed = 0; m_since = 0; m_miss = 0; m_acc = '0;
  endtask

  // Called at posedge+1: predict, drive, then check outputs one edge later.
  task automatic step(input bit v, input logic [BLOCK_W-1:0] d);
    bit mk, slot, rm, bip;
    rm = 0; bip = 0;
    if (v) begin
      mk   = ref_is_marker(d);
      slot = (m_lock || m_cand) && (m_since == GAP);
      if (m_lock) begin
        if (!slot) m_since++;
        else begin
          rm = 1; m_since = 0;
          if (mk) begin
            bip = m_armed && (d[2+24 +: 8] != m_acc);
            m_miss = 0;
          end else begin
            m_miss++;
            if (m_miss == LOSS) begin m_lock = 0; m_miss = 0; m_armed = 0; end
          end
        end
      end else if (m_cand) begin
        if (!slot) m_since++;
        else if (mk) begin rm = 1; m_cand = 0; m_lock = 1; m_since = 0; m_miss = 0; end
        else begin m_cand = 0; m_since = 0; m_armed = 0; end
      end else if (mk) begin
        rm = 1; m_cand = 1; m_since = 0;
      end
      if (rm) m_acc = ref_par(d);
      else    m_acc = m_acc ^ ref_par(d);
      if (rm && mk) m_armed = 1;
    end
    valid_i = v;
    data_i  = d;
    @(posedge clk);
    #1;
    check("valid_o", valid_o, v && !rm);
    check("am_v_o", am_v_o, v && rm);
    check("lock_o", lock_o, m_lock);
    check("bip_err_o", bip_err_o, BIP_EN && bip);
    check("data_o", data_o, d);
  endtask

  task automatic gap_data();
    for (int i = 0; i < GAP; i++) step(1'b1, mk_data());
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, valid_o, 1'b0);
    check({tag, "_am"}, am_v_o, 1'b0);
    check({tag, "_lock"}, lock_o, 1'b0);
    check({tag, "_bip"}, bip_err_o, 1'b0);
    check({tag, "_data"}, data_o, '0);
  endtask

  task automatic mid_reset();
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    model_clear();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [BLOCK_W-1:0] b;
    reset = 1'b1; valid_i = 1'b0; data_i = '0;
    model_clear();
    #1 check_all_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // Lock acquisition
    step(1'b1, mk_marker(8'h00));
    check("first_marker_lock", lock_o, 1'b0);
    gap_data();
    step(1'b1, mk_marker(8'h00));
    check("locked_on_2nd", lock_o, 1'b1);

    // BIP correct, then corrupted
    gap_data();
    step(1'b1, mk_marker(m_acc));
    check("bip_good", bip_err_o, 1'b0);
    gap_data();
    step(1'b1, mk_marker(m_acc ^ 8'h01));
    check("bip_bad", bip_err_o, BIP_EN);
    step(1'b1, mk_data());
    check("bip_pulse_end", bip_err_o, 1'b0);
    check("bip_lock_held", lock_o, 1'b1);

    // Lock loss: 3 misses + match holds, then 4 misses drop
    for (int i = 0; i < GAP - 1; i++) step(1'b1, mk_data());
    for (int r = 0; r < LOSS - 1; r++) begin
      step(1'b1, mk_data());
      check("miss_removed", am_v_o, 1'b1);
      gap_data();
    end
    step(1'b1, mk_marker(m_acc));
    check("miss_recover_lock", lock_o, 1'b1);
    for (int r = 0; r < LOSS; r++) begin
      gap_data();
      step(1'b1, mk_data());
    end
    check("lock_lost", lock_o, 1'b0);

    // False candidate
    step(1'b1, mk_marker(8'h5a));
    gap_data();
    step(1'b1, mk_data());
    check("false_cand_valid", valid_o, 1'b1);
    check("false_cand_lock", lock_o, 1'b0);

    // Bubbles inside the gap, then reset mid-gap and relock
    step(1'b1, mk_marker(8'h00));
    gap_data();
    step(1'b1, mk_marker(8'h00));
    step(1'b1, mk_data());
    step(1'b0, mk_data());
    step(1'b0, mk_data());
    step(1'b1, mk_data());
    step(1'b0, mk_marker(8'h00));
    step(1'b1, mk_data());
    step(1'b1, mk_data());
    step(1'b0, mk_data());
    step(1'b1, mk_marker(m_acc));
    check("bubble_slot_am", am_v_o, 1'b1);
    check("bubble_lock", lock_o, 1'b1);
    step(1'b1, mk_data());
    step(1'b1, mk_data());
    mid_reset();
    step(1'b1, mk_marker(8'h00));
    gap_data();
    step(1'b1, mk_marker(8'h00));
    check("relock", lock_o, 1'b1);

    // Randomized stream
    for (int c = 0; c < 4000; c++) begin
      bit v = ($urandom_range(0, 9) < 8);
      int r = $urandom_range(0, 19);
      if (c == 2000) mid_reset();
      if ((!m_lock && !m_cand) || m_since == GAP) begin
        if (r < 13) b = mk_marker((r < 9) ? m_acc : 8'($urandom()));
        else if (r == 13) begin
          b = mk_marker(8'($urandom()));
          b[2+56 +: 8] = b[2+56 +: 8] ^ 8'h10;
        end else if (r == 14) begin
          b = mk_marker(8'h00);
          b[2+8*($urandom_range(0, 2)) +: 8] ^= 8'h04;
        end else b = mk_data();
      end else begin
        b = (r == 0) ? mk_marker(m_acc) : mk_data();
      end
      step(v, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
